lift_shaft_model: RTL and testbench
===================================

Name: lift_shaft_model

Overview:
- Car/shaft responder for the lift controller.
- Consumes the controller's motion, direction and door_open outputs.
- Produces the floor-sense vector the controller uses for stopping decisions.
- Used as the plant in system benches and as the FPGA demo car model; it contains a travel timer, a floor position register and a fault detector.

Parameters:
- N_FLOORS, 8, number of floors (>=2); floor 0 is the bottom floor.
- TRAVEL_CYCLES, 16, clock cycles to travel between adjacent floors (>=1).
- RESET_FLOOR, 0, floor index the car occupies after reset (< N_FLOORS).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_motion  input  1  controller motion command; 1 = move.
- i_direction  input  1  controller direction; 1 = up, 0 = down.
- i_door_open  input  1  door state from the door controller.
- o_flr_pos  output  N_FLOORS  one-hot floor sense when level at a floor; all-zero between floors.
- o_flr_idx  output  $clog2(N_FLOORS)  index of the last floor reached.
- o_moving  output  1  car is between floors.
- o_arrive  output  1  one-cycle pulse on the cycle the car becomes level at a floor.
- o_fault  output  1  sticky fault flag.

Behaviour:
- Reset (asynchronous, active-high; also mid-travel):
  - state=AT_FLOOR, o_flr_idx=RESET_FLOOR, o_flr_pos=onehot(RESET_FLOOR).
  - o_moving=0, o_arrive=0, o_fault=0, timer=0.
- States: AT_FLOOR, MOVE_UP, MOVE_DN, FAULT.
- AT_FLOOR:
  - Inputs are sampled each clk.
  - If i_motion=1, i_door_open=0 and the move is legal (up with idx<N_FLOORS-1, or down with idx>0):
    - go to MOVE_UP/MOVE_DN next cycle.
    - o_flr_pos=0, o_moving=1 and the timer loads TRAVEL_CYCLES-1, all on that same next cycle.
  - Illegal move (up at top floor, down at floor 0): go to FAULT.
- MOVE_UP / MOVE_DN:
  - Timer decrements each cycle.
  - On the cycle the timer is 0, the next state is AT_FLOOR with idx+1/idx-1.
  - On arrival: o_flr_pos=onehot(new idx), o_arrive=1 for exactly one cycle, o_moving=0.
  - Arrival therefore occurs TRAVEL_CYCLES cycles after o_moving rises.
- Mid-travel command changes:
  - i_motion drop and i_direction flips are ignored; the car always completes travel to the adjacent floor.
  - No stop between floors.
- Pass-through: if i_motion is still 1 on arrival, the car is level for exactly one cycle (o_flr_pos visible one cycle), then departs under the normal AT_FLOOR rules.
- i_door_open=1 while in MOVE_*: go to FAULT.
- FAULT:
  - o_fault=1, o_moving=0.
  - o_flr_pos holds its value on entry (zero if entered mid-travel).
  - o_flr_idx holds its value.
  - Exit only via reset.
- Simultaneous reset and any event: reset wins.
- Timer width is $clog2(TRAVEL_CYCLES+1). The floor index never wraps; out-of-range moves go to FAULT, not wrap.

Optional Feature:
- Macro: LIFT_SHAFT_DOOR_INTERLOCK_EN. It selects what happens for i_motion=1 with i_door_open=1 in AT_FLOOR.
- Defined: this condition goes to FAULT next cycle (interlock violation is detected).
- Undefined: the condition is a hold. The car stays in AT_FLOOR with outputs unchanged and no fault, and departs once the door closes and motion is still asserted.
- Door opening during MOVE_* faults in both builds.

Decomposition:
- Shared package lift_pkg holds:
  - shaft_state_t enum: AT_FLOOR, MOVE_UP, MOVE_DN, FAULT.
  - constants DIR_UP=1'b1 and DIR_DN=1'b0, which the controller ALU also uses.
- One sub-module, lift_travel_timer: load/decrement/zero-flag down-counter parameterised by TRAVEL_CYCLES.

Test Plan:
1. Reset with N_FLOORS=8, TRAVEL_CYCLES=4, RESET_FLOOR=0 -> o_flr_pos=8'b0000_0001, o_flr_idx=0, o_fault=0, o_moving=0.
2. i_motion=1, i_direction=1, door closed, held one cycle from floor 0 -> o_moving=1 for 4 cycles, then o_flr_pos=8'b0000_0010, o_arrive pulses once, o_flr_idx=1.
3. Motion held up continuously from floor 2 -> floors 3, 4, 5 are each visible exactly one cycle, with 4-cycle gaps of o_flr_pos=0.
4. At floor 7, command up -> FAULT next cycle, o_fault=1 sticky. Same result for down at floor 0.
5. Door open asserted during MOVE_DN -> o_fault=1 and o_moving=0 next cycle. Then reset -> floor RESET_FLOOR, fault clears.
6. Door open plus motion at floor 3 -> with the macro defined, o_fault=1; without it, the car holds at floor 3 and departs on the cycle after the door closes.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared lift definitions: car/shaft state encoding and direction constants
// used by both the shaft model and the controller datapath.
package lift_pkg;

  typedef enum logic [1:0] {
    AT_FLOOR = 2'd0,
    MOVE_UP  = 2'd1,
    MOVE_DN  = 2'd2,
    FAULT    = 2'd3
  } shaft_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage : lift_pkg

// File: rtl/lift_travel_timer.sv
// Inter-floor travel down-counter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load_i     : load TRAVEL_CYCLES-1 (start of a floor-to-floor trip)
//   dec_i      : decrement by one, saturating at zero
//   zero_o     : registered flag, high while the count is zero
module lift_travel_timer #(
  parameter int unsigned TRAVEL_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CNT_W = $clog2(TRAVEL_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  // Next count; the zero flag is computed alongside so it stays registered.
  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (load_i) begin
      cnt_d  = CNT_W'(TRAVEL_CYCLES - 1);
      zero_d = (TRAVEL_CYCLES == 1);
    end else if (dec_i && !zero_q) begin
      cnt_d  = cnt_q - CNT_W'(1);
      zero_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule : lift_travel_timer

// File: rtl/lift_shaft_model.sv
// Lift car/shaft plant model: turns controller motion/direction/door into
// floor-sense outputs, with a travel timer, floor register and fault detector.
// Optional build macro: LIFT_SHAFT_DOOR_INTERLOCK_EN -- when defined, a move
// request with the door open at a floor is a fault; otherwise it is a hold.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_motion     : move command (1 = move)
//   i_direction  : 1 = up, 0 = down
//   i_door_open  : door state
//   o_flr_pos    : one-hot floor sense when level, zero between floors
//   o_flr_idx    : index of last floor reached
//   o_moving     : car is between floors
//   o_arrive     : one-cycle pulse when the car becomes level
//   o_fault      : sticky fault flag
module lift_shaft_model
  import lift_pkg::*;
#(
  parameter int unsigned N_FLOORS      = 8,
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned RESET_FLOOR   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_motion,
  input  logic                        i_direction,
  input  logic                        i_door_open,
  output logic [N_FLOORS-1:0]         o_flr_pos,
  output logic [$clog2(N_FLOORS)-1:0] o_flr_idx,
  output logic                        o_moving,
  output logic                        o_arrive,
  output logic                        o_fault
);

  localparam int unsigned IDX_W = $clog2(N_FLOORS);

  shaft_state_t        state_q, state_d;
  logic [N_FLOORS-1:0] pos_q, pos_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                moving_q, moving_d;
  logic                arrive_q, arrive_d;
  logic                fault_q, fault_d;

  logic tmr_load_c;
  logic tmr_dec_c;
  logic tmr_zero;

  lift_travel_timer #(
    .TRAVEL_CYCLES (TRAVEL_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (tmr_load_c),
    .dec_i  (tmr_dec_c),
    .zero_o (tmr_zero)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    idx_d      = idx_q;
    moving_d   = moving_q;
    arrive_d   = 1'b0;
    fault_d    = fault_q;
    tmr_load_c = 1'b0;
    tmr_dec_c  = 1'b0;

    case (state_q)
      AT_FLOOR: begin
        if (i_motion) begin
          if (i_door_open) begin
`ifdef LIFT_SHAFT_DOOR_INTERLOCK_EN
            state_d  = FAULT;
            fault_d  = 1'b1;
            moving_d = 1'b0;
`else
            // Door still open: hold at the floor until it closes.
            state_d  = AT_FLOOR;
`endif
          end else if (i_direction == DIR_UP) begin
            if (idx_q == IDX_W'(N_FLOORS - 1)) begin
              state_d  = FAULT;
              fault_d  = 1'b1;
              moving_d = 1'b0;
            end else begin
              state_d    = MOVE_UP;
              pos_d      = '0;
              moving_d   = 1'b1;
              tmr_load_c = 1'b1;
            end
          end else begin
            if (idx_q == '0) begin
              state_d  = FAULT;
              fault_d  = 1'b1;
              moving_d = 1'b0;
            end else begin
              state_d    = MOVE_DN;
              pos_d      = '0;
              moving_d   = 1'b1;
              tmr_load_c = 1'b1;
            end
          end
        end
      end

      MOVE_UP, MOVE_DN: begin
        // Command changes are ignored mid-travel; only the door can interrupt.
        if (i_door_open) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          moving_d = 1'b0;
        end else if (tmr_zero) begin
          state_d  = AT_FLOOR;
          idx_d    = (state_q == MOVE_UP) ? (idx_q + IDX_W'(1))
                                          : (idx_q - IDX_W'(1));
          pos_d    = N_FLOORS'(1) << idx_d;
          moving_d = 1'b0;
          arrive_d = 1'b1;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end

      FAULT: begin
        moving_d = 1'b0;
        fault_d  = 1'b1;
      end

      default: begin
        state_d  = FAULT;
        moving_d = 1'b0;
        fault_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= AT_FLOOR;
      pos_q    <= N_FLOORS'(1) << RESET_FLOOR;
      idx_q    <= IDX_W'(RESET_FLOOR);
      moving_q <= 1'b0;
      arrive_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      idx_q    <= idx_d;
      moving_q <= moving_d;
      arrive_q <= arrive_d;
      fault_q  <= fault_d;
    end
  end

  assign o_flr_pos = pos_q;
  assign o_flr_idx = idx_q;
  assign o_moving  = moving_q;
  assign o_arrive  = arrive_q;
  assign o_fault   = fault_q;

endmodule : lift_shaft_model

// File: tb/tb_lift_shaft_model.sv
// Self-checking bench for lift_shaft_model (N_FLOORS=8, TRAVEL_CYCLES=4).
// Expected outputs come from a behavioural car model tracking floor number,
// elapsed travel ticks and a fault flag.
module tb_lift_shaft_model;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int RF = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_motion = 1'b0;
  logic       i_direction = 1'b0;
  logic       i_door_open = 1'b0;
  logic [7:0] o_flr_pos;
  logic [2:0] o_flr_idx;
  logic       o_moving;
  logic       o_arrive;
  logic       o_fault;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural car model
  int m_floor;
  int m_target;
  int m_elapsed;
  bit m_level;
  bit m_trav;
  bit m_fault;
  bit m_arr;

  lift_shaft_model #(
    .N_FLOORS      (NF),
    .TRAVEL_CYCLES (TC),
    .RESET_FLOOR   (RF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_motion    (i_motion),
    .i_direction (i_direction),
    .i_door_open (i_door_open),
    .o_flr_pos   (o_flr_pos),
    .o_flr_idx   (o_flr_idx),
    .o_moving    (o_moving),
    .o_arrive    (o_arrive),
    .o_fault     (o_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_pos();
    logic [7:0] one8;
    one8 = 8'd1;
    return m_level ? (one8 << m_floor) : 8'd0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pos"},    32'(o_flr_pos), 32'(exp_pos()));
    chk({tag, ".idx"},    32'(o_flr_idx), 32'(m_floor));
    chk({tag, ".moving"}, 32'(o_moving),  32'(m_trav));
    chk({tag, ".arrive"}, 32'(o_arrive),  32'(m_arr));
    chk({tag, ".fault"},  32'(o_fault),   32'(m_fault));
  endtask

  function automatic void model_reset();
    m_floor   = RF;
    m_target  = RF;
    m_elapsed = 0;
    m_level   = 1'b1;
    m_trav    = 1'b0;
    m_fault   = 1'b0;
    m_arr     = 1'b0;
  endfunction

  // One clock of car behaviour given the inputs sampled at that edge.
  function automatic void model_step(input bit mo, input bit di, input bit dr);
    m_arr = 1'b0;
    if (m_fault) return;
    if (m_trav) begin
      if (dr) begin
        m_fault = 1'b1;
        m_trav  = 1'b0;
      end else begin
        m_elapsed++;
        if (m_elapsed == TC) begin
          m_floor = m_target;
          m_trav  = 1'b0;
          m_level = 1'b1;
          m_arr   = 1'b1;
        end
      end
    end else if (mo) begin
      if (dr) begin
`ifdef LIFT_SHAFT_DOOR_INTERLOCK_EN
        m_fault = 1'b1;
`endif
      end else begin
        m_target = di ? m_floor + 1 : m_floor - 1;
        if (m_target < 0 || m_target >= NF) begin
          m_fault = 1'b1;
        end else begin
          m_trav    = 1'b1;
          m_level   = 1'b0;
          m_elapsed = 0;
        end
      end
    end
  endfunction

  task automatic step(input bit mo, input bit di, input bit dr, input string tag);
    i_motion    = mo;
    i_direction = di;
    i_door_open = dr;
    @(posedge clk);
    model_step(mo, di, dr);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    i_motion    = 1'b0;
    i_direction = 1'b0;
    i_door_open = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b0;
  endtask

  // Drive the car to floor f; a bound on cycles guards against a stuck DUT.
  task automatic goto_floor(input int f, input string tag);
    int n;
    n = 0;
    while (!(m_level && !m_trav && m_floor == f) && !m_fault && n < 200) begin
      step(m_level && !m_trav && m_floor != f, f > m_floor, 1'b0, tag);
      n++;
    end
    chk({tag, ".reached"}, 32'(o_flr_idx), 32'(f));
  endtask

  initial begin
    int lvl_cnt;
    int arr_cnt;

    // 1. Reset
    do_reset("t1");
    chk("t1.pos_const", 32'(o_flr_pos), 32'h01);

    // 2. Single up command from floor 0
    step(1'b1, 1'b1, 1'b0, "t2.go");
    arr_cnt = 0;
    for (int i = 0; i < TC + 1; i++) begin
      step(1'b0, 1'b0, 1'b0, "t2.trav");
      if (o_arrive) arr_cnt++;
    end
    chk("t2.pos_const", 32'(o_flr_pos), 32'h02);
    chk("t2.arr_cnt", 32'(arr_cnt), 32'd1);

    // 3. Held motion from floor 2: floors 3,4,5 each level one cycle
    goto_floor(2, "t3.pre");
    lvl_cnt = 0;
    for (int i = 0; i < 3 * (TC + 1); i++) begin
      step(1'b1, 1'b1, 1'b0, "t3.hold");
      if (o_flr_pos != 8'd0) lvl_cnt++;
    end
    chk("t3.level_cycles", 32'(lvl_cnt), 32'd3);
    chk("t3.idx_const", 32'(o_flr_idx), 32'd5);
    step(1'b0, 1'b1, 1'b0, "t3.idle");

    // 4. Out-of-range moves fault and stick
    goto_floor(7, "t4.pre");
    step(1'b1, 1'b1, 1'b0, "t4.top");
    chk("t4.top_fault", 32'(o_fault), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "t4.sticky");
    do_reset("t4.rst");
    step(1'b1, 1'b0, 1'b0, "t4.bot");
    chk("t4.bot_fault", 32'(o_fault), 32'd1);
    do_reset("t4.rst2");

    // 5. Door open mid-travel, then reset
    goto_floor(2, "t5.pre");
    step(1'b1, 1'b0, 1'b0, "t5.go");
    step(1'b0, 1'b1, 1'b0, "t5.trav");
    step(1'b0, 1'b0, 1'b1, "t5.door");
    chk("t5.fault", 32'(o_fault), 32'd1);
    chk("t5.moving", 32'(o_moving), 32'd0);
    step(1'b0, 1'b0, 1'b0, "t5.sticky");
    do_reset("t5.rst");
    // asynchronous reset mid-travel
    step(1'b1, 1'b1, 1'b0, "t5.go2");
    step(1'b0, 1'b0, 1'b0, "t5.trav2");
    do_reset("t5.midrst");

    // 6. Door open with motion at floor 3
    goto_floor(3, "t6.pre");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, "t6.door");
    step(1'b1, 1'b1, 1'b0, "t6.close");
`ifdef LIFT_SHAFT_DOOR_INTERLOCK_EN
    chk("t6.fault", 32'(o_fault), 32'd1);
`else
    chk("t6.depart", 32'(o_moving), 32'd1);
`endif
    for (int i = 0; i < TC + 1; i++) step(1'b0, 1'b0, 1'b0, "t6.after");
    do_reset("t6.rst");

    // Randomized phase against the model
    for (int i = 0; i < 800; i++) begin
      if (m_fault && $urandom_range(0, 3) == 0) begin
        do_reset("rnd.rst");
      end else if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd.midrst");
      end else begin
        step($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < 3, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_lift_shaft_model
